tone_generator: RTL and testbench
=================================

TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have parameter: COUNT_W, 14, width of half-period count input.
REQ-002 SHALL have port: clk_5MHz  input  1  system clock, 5 MHz.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: countStart  input  COUNT_W  half-period length in clk_5MHz cycles; 0 = silence.
REQ-005 SHALL have port: enable  input  1  tone gate; 0 requests silence.
REQ-006 SHALL have port: speaker  output  1  square-wave audio output, registered.
REQ-007 SHALL have port: tone_active  output  1  high while a tone period is in progress.
REQ-008 SHALL have port: period_tick  output  1  one-cycle pulse on the last cycle of each full period.
REQ-009 SHALL use one clock, clk_5MHz; reset SHALL be synchronous and active-high.

Function
REQ-010 SHALL implement FSM states: SILENT, HIGH, LOW.
REQ-011 SILENT: speaker=0, tone_active=0; a period starts when enable=1 and countStart!=0.
REQ-012 On start: latch countStart into active_period; load half counter with countStart-1; next state HIGH.
REQ-013 speaker SHALL be 1 on the first cycle after the start condition is sampled (1-cycle latency).
REQ-014 HIGH and LOW SHALL each last exactly active_period cycles; the counter decrements once per cycle.
REQ-015 HIGH at count 0 -> LOW, counter reloaded with active_period-1.
REQ-016 LOW at count 0 -> period boundary: period_tick=1 on that cycle.
REQ-017 At the boundary, if enable=1 and countStart!=0: relatch active_period from countStart and go to HIGH; else go to SILENT.
REQ-018 Changes to countStart or enable between boundaries SHALL be ignored; no half-period is truncated or extended.
REQ-019 countStart=1 SHALL give speaker toggling every cycle (period 2 cycles).
REQ-020 Maximum countStart (2^COUNT_W-1) SHALL count without overflow; counter width = COUNT_W.
REQ-021 tone_active SHALL be 1 in HIGH and LOW, 0 in SILENT.
REQ-022 speaker SHALL be a direct register output, glitch-free, with no combinational path from inputs.
REQ-023 Output frequency SHALL equal 5 MHz / (2 * active_period).

Reset
REQ-024 Reset SHALL force state SILENT, counter 0, active_period 0, speaker 0, tone_active 0, period_tick 0 on the next clock edge.
REQ-025 Reset asserted mid-period SHALL abort the period immediately; the period SHALL NOT complete.
REQ-026 Reset SHALL take priority over all other conditions.
REQ-027 After reset deasserts, a new start SHALL follow REQ-011 to REQ-013.

Structure
REQ-028 COUNT_W default and the FSM state encoding SHALL live in shared package piano_pkg.
REQ-029 The reloadable down-counter SHALL be one sub-module, tone_halfcount, with load, load value, and zero-flag ports.
REQ-030 The FSM, active_period register, and output registers SHALL stay in tone_generator.

Verification
REQ-031 countStart=4, enable=1 from SILENT -> speaker 1 for 4 cycles, then 0 for 4 cycles, repeating; period_tick every 8 cycles on the last LOW cycle.
REQ-032 countStart=9579 -> measured period 19158 cycles (~261 Hz); tone_active held at 1 throughout.
REQ-033 countStart changed 4->6 during the 2nd HIGH cycle -> current period completes at 4/4; the next period runs at 6/6.
REQ-034 countStart set to 0 (or enable dropped) during HIGH -> HIGH and LOW complete in full, then SILENT; speaker 0, tone_active 0 on the cycle after the boundary.
REQ-035 reset pulsed in the 3rd HIGH cycle of countStart=8 -> speaker 0 and tone_active 0 on the next edge; a restart after deassert gives a full 8-cycle HIGH.
REQ-036 countStart=1 -> speaker toggles every cycle; period_tick every 2 cycles.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone path:
// default counter width and tone FSM encoding.
package piano_pkg;

   localparam int COUNT_W_DEF = 14;

   typedef enum logic [1:0] {
      SILENT = 2'd0,
      HIGH   = 2'd1,
      LOW    = 2'd2
   } tone_state_t;

endpackage

// File: rtl/tone_halfcount.sv
// Reloadable half-period down-counter.
// Holds at zero; flags zero and one for look-ahead.
module tone_halfcount #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero,
   output logic         o_one
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);
   assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator: HIGH/LOW halves of
// active_period cycles each, retimed only at period ends.
module tone_generator
   import piano_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic               clk_5MHz,
   input  logic               reset,
   input  logic [COUNT_W-1:0] countStart,
   input  logic               enable,
   output logic               speaker,
   output logic               tone_active,
   output logic               period_tick
);

   tone_state_t        r_state;
   logic [COUNT_W-1:0] r_active;
   logic               w_start;
   logic               w_zero;
   logic               w_one;
   logic               w_load;
   logic [COUNT_W-1:0] w_load_val;
   logic               w_tick_next;

   assign w_start = enable && (countStart != '0);

   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      unique case (r_state)
         SILENT: begin
            if (w_start) begin
               w_load     = 1'b1;
               w_load_val = countStart - 1'b1;
            end
         end
         HIGH: begin
            if (w_zero) begin
               w_load     = 1'b1;
               w_load_val = r_active - 1'b1;
            end
         end
         LOW: begin
            if (w_zero && w_start) begin
               w_load     = 1'b1;
               w_load_val = countStart - 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Tick is registered, so predict the last LOW cycle one cycle early.
   assign w_tick_next =
      (r_state == HIGH && w_zero && r_active == COUNT_W'(1)) ||
      (r_state == LOW && w_one);

   tone_halfcount #(.W(COUNT_W)) u_halfcount (
      .clk        (clk_5MHz),
      .i_rst      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero),
      .o_one      (w_one)
   );

   always_ff @(posedge clk_5MHz) begin
      if (reset) begin
         r_state     <= SILENT;
         r_active    <= '0;
         speaker     <= 1'b0;
         tone_active <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         period_tick <= w_tick_next;
         unique case (r_state)
            SILENT: begin
               if (w_start) begin
                  r_state     <= HIGH;
                  r_active    <= countStart;
                  speaker     <= 1'b1;
                  tone_active <= 1'b1;
               end
            end
            HIGH: begin
               if (w_zero) begin
                  r_state <= LOW;
                  speaker <= 1'b0;
               end
            end
            LOW: begin
               if (w_zero) begin
                  if (w_start) begin
                     r_state  <= HIGH;
                     r_active <= countStart;
                     speaker  <= 1'b1;
                  end else begin
                     r_state     <= SILENT;
                     r_active    <= '0;
                     speaker     <= 1'b0;
                     tone_active <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= SILENT;
               speaker     <= 1'b0;
               tone_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: queue-based period model
// plus directed scenarios and random stimulus.
module tb_tone_generator;

   localparam int CW = 14;

   logic          clk_5MHz = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] countStart;
   logic          speaker;
   logic          tone_active;
   logic          period_tick;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   always #100 clk_5MHz = ~clk_5MHz;

   tone_generator #(.COUNT_W(CW)) dut (
      .clk_5MHz    (clk_5MHz),
      .reset       (reset),
      .countStart  (countStart),
      .enable      (enable),
      .speaker     (speaker),
      .tone_active (tone_active),
      .period_tick (period_tick)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
   endtask

   // Model: each started period is a list of per-cycle
   // {speaker, tone_active, tick} entries played out in order.
   logic [2:0] q[$];
   logic [2:0] exp_o = 3'b000;

   always @(posedge clk_5MHz) begin
      if (reset) begin
         q.delete();
         chk_on = 1'b1;
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (q.size() == 0 && enable && countStart != 0) begin
            for (int i = 0; i < int'(countStart); i++)
               q.push_back(3'b110);
            for (int i = 0; i < int'(countStart); i++)
               q.push_back((i == int'(countStart) - 1) ? 3'b011 : 3'b010);
         end
      end
      exp_o = (q.size() > 0) ? q[0] : 3'b000;
   end

   always @(negedge clk_5MHz) begin
      if (chk_on) begin
         chk("model_speaker", speaker, exp_o[2]);
         chk("model_active", tone_active, exp_o[1]);
         chk("model_tick", period_tick, exp_o[0]);
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk_5MHz);
   endtask

   task automatic wait_tick(string tag, int limit);
      int n = 0;
      while (period_tick !== 1'b1 && n < limit) begin
         cyc(1);
         n++;
      end
      chk(tag, period_tick, 1);
   endtask

   initial begin
      int n;
      int r;
      reset = 1'b1;
      enable = 1'b0;
      countStart = '0;
      cyc(3);
      chk("rst_speaker", speaker, 0);
      chk("rst_active", tone_active, 0);
      chk("rst_tick", period_tick, 0);
      reset = 1'b0;
      cyc(3);

      // 4/4 square wave from silence
      countStart = 4;
      enable = 1'b1;
      cyc(1);
      for (int i = 0; i < 24; i++) begin
         chk("c4_speaker", speaker, ((i % 8) < 4) ? 1 : 0);
         chk("c4_tick", period_tick, ((i % 8) == 7) ? 1 : 0);
         cyc(1);
      end

      // countStart change mid-HIGH takes effect next period
      wait_tick("c33_sync", 20);
      cyc(2);
      countStart = 6;
      for (int j = 1; j < 20; j++) begin
         chk("c33_speaker", speaker,
             (j < 8) ? ((j < 4) ? 1 : 0) : (((j - 8) < 6) ? 1 : 0));
         cyc(1);
      end

      // countStart=0 during HIGH: period finishes, then silence
      wait_tick("c34_sync", 20);
      cyc(2);
      countStart = 0;
      for (int j = 1; j < 12; j++) begin
         chk("c34_speaker", speaker, (j < 6) ? 1 : 0);
         chk("c34_active", tone_active, 1);
         cyc(1);
      end
      chk("c34_silent_spk", speaker, 0);
      chk("c34_silent_act", tone_active, 0);

      // enable dropped during HIGH
      countStart = 5;
      cyc(1);
      enable = 1'b0;
      cyc(12);
      chk("en_drop_act", tone_active, 0);

      // reset in 3rd HIGH cycle of an 8/8 tone
      countStart = 8;
      enable = 1'b1;
      cyc(3);
      chk("c35_high3", speaker, 1);
      reset = 1'b1;
      cyc(1);
      chk("c35_rst_spk", speaker, 0);
      chk("c35_rst_act", tone_active, 0);
      reset = 1'b0;
      cyc(1);
      for (int i = 0; i < 8; i++) begin
         chk("c35_restart_high", speaker, 1);
         cyc(1);
      end
      chk("c35_restart_low", speaker, 0);

      // countStart=1 toggles every cycle
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      enable = 1'b0;
      countStart = 1;
      cyc(1);
      enable = 1'b1;
      cyc(1);
      for (int i = 0; i < 10; i++) begin
         chk("c36_speaker", speaker, (i % 2 == 0) ? 1 : 0);
         chk("c36_tick", period_tick, (i % 2 == 1) ? 1 : 0);
         cyc(1);
      end

      // maximum count loads without overflow
      countStart = '1;
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(300);
      chk("max_speaker", speaker, 1);

      // 9579 -> period of 19158 cycles
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      countStart = 9579;
      wait_tick("c32_first", 40000);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (period_tick !== 1'b1 && n < 40000);
      chk("c32_period", n, 19158);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;

      // random inputs against the model
      enable = 1'b1;
      countStart = 3;
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 5) countStart = CW'($urandom_range(0, 12));
         else if (r < 8) enable = ~enable;
         reset = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
